// File: rtl/bldc_encoder_angle_pkg.sv
// Shared encodings for the quadrature front end: Gray state names, step codes and decode.
// Pure combinational helpers; no state lives here.
package bldc_pkg;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_state_t;

  typedef enum logic [1:0] {
    STEP_IDLE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Forward Gray order is 00->01->11->10->00; any double-bit change is illegal.
  function automatic step_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_IDLE;
    case ({prev, cur})
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: s = STEP_UP;
      {Q01, Q00}, {Q11, Q01}, {Q10, Q11}, {Q00, Q10}: s = STEP_DOWN;
      {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: s = STEP_ILLEGAL;
      default:                                        s = STEP_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bldc_encoder_angle_quad_input_filter.sv
// 2-FF synchroniser plus stability filter for one raw encoder pin.
// Output follows a change FILTER_LEN+1 edges after the pin is first sampled; no backpressure.
module quad_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_o = filt_q;

endmodule

// File: rtl/bldc_encoder_angle.sv
// Quadrature A/B/index to electrical angle, signed position and sticky fault status.
// Pin change to feedback/position takes FILTER_LEN+3 cycles; always accepts input, no backpressure.
module bldc_encoder_angle
  import bldc_pkg::*;
#(
  parameter int   COUNTS_PER_EREV = 1024,
  parameter int   FILTER_LEN      = 3,
  parameter logic INDEX_POLARITY  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_index,
  input  logic        index_enable,
  input  logic        clear_error,
  output logic [15:0] feedback,
  output logic [31:0] position,
  output logic        direction,
  output logic        index_seen,
  output logic        error,
  output logic [7:0]  error_count
);

  localparam logic [16:0] CPE    = 17'(COUNTS_PER_EREV);
  localparam logic [15:0] CPE_M1 = 16'(COUNTS_PER_EREV - 1);

  logic a_filt, b_filt, idx_filt;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .din_i(enc_a), .dout_o(a_filt)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .din_i(enc_b), .dout_o(b_filt)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_idx (
    .clk(clk), .rst(rst), .din_i(enc_index), .dout_o(idx_filt)
  );

  logic [1:0]  ab_prev_q;
  logic        idx_prev_q;
  logic [15:0] fb_q, fb_d;
  logic [31:0] pos_q, pos_d;
  logic        dir_q, dir_d;
  logic        idx_seen_q, idx_seen_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  step_t       step;
  logic        index_hit;
  logic [16:0] fb_next;
  logic [15:0] fb_wrapped;

  assign step      = quad_decode(ab_prev_q, {a_filt, b_filt});
  assign index_hit = enable && index_enable &&
                     (idx_filt == INDEX_POLARITY) && (idx_prev_q != INDEX_POLARITY);

  // Unwrapped angle in 17 bits: bit 16 set means we stepped below zero.
  always_comb begin
    fb_next = {1'b0, fb_q};
    case (step)
      STEP_UP:   fb_next = {1'b0, fb_q} + 17'd1;
      STEP_DOWN: fb_next = {1'b0, fb_q} - 17'd1;
      default:   fb_next = {1'b0, fb_q};
    endcase

    if (fb_next == CPE) begin
      fb_wrapped = '0;
    end else if (fb_next[16]) begin
      fb_wrapped = CPE_M1;
    end else begin
      fb_wrapped = fb_next[15:0];
    end
  end

  always_comb begin
    fb_d       = fb_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    idx_seen_d = idx_seen_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;

    if (enable) begin
      fb_d = fb_wrapped;
      case (step)
        STEP_UP: begin
          pos_d = pos_q + 32'd1;
          dir_d = 1'b1;
        end
        STEP_DOWN: begin
          pos_d = pos_q - 32'd1;
          dir_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (index_hit) begin
      fb_d       = '0;
      idx_seen_d = 1'b1;
    end

    // A fault landing on the clearing edge is the first fault of the new window.
    if (step == STEP_ILLEGAL) begin
      err_d = 1'b1;
      if (clear_error) begin
        err_cnt_d = 8'd1;
      end else if (err_cnt_q != ERR_CNT_MAX) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (clear_error) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ab_prev_q  <= 2'b00;
      idx_prev_q <= 1'b0;
      fb_q       <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      idx_seen_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      ab_prev_q  <= {a_filt, b_filt};
      idx_prev_q <= idx_filt;
      fb_q       <= fb_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      idx_seen_q <= idx_seen_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign feedback    = fb_q;
  assign position    = pos_q;
  assign direction   = dir_q;
  assign index_seen  = idx_seen_q;
  assign error       = err_q;
  assign error_count = err_cnt_q;

endmodule

// File: tb/tb_bldc_encoder_angle.sv
// Directed bench for bldc_encoder_angle at default parameters (1024 counts, filter 3).
module tb_bldc_encoder_angle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        enc_index = 1'b0;
  logic        index_enable = 1'b0;
  logic        clear_error = 1'b0;
  logic [15:0] feedback;
  logic [31:0] position;
  logic        direction;
  logic        index_seen;
  logic        error;
  logic [7:0]  error_count;

  int n_checks = 0;
  int n_fail   = 0;

  bldc_encoder_angle dut (
    .clk(clk), .rst(rst), .enable(enable),
    .enc_a(enc_a), .enc_b(enc_b), .enc_index(enc_index),
    .index_enable(index_enable), .clear_error(clear_error),
    .feedback(feedback), .position(position), .direction(direction),
    .index_seen(index_seen), .error(error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic a, input logic b, input int hold);
    enc_a = a;
    enc_b = b;
    repeat (hold) tick();
  endtask

  task automatic up_cycle(input int hold);
    set_ab(1'b0, 1'b1, hold);
    set_ab(1'b1, 1'b1, hold);
    set_ab(1'b1, 1'b0, hold);
    set_ab(1'b0, 1'b0, hold);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    enc_index = 1'b0;
    index_enable = 1'b0;
    clear_error = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL reset_feedback got %0d expected 0", feedback); end
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL reset_position got %0h expected 0", position); end
    n_checks++; if (direction !== 1'b0) begin n_fail++; $display("FAIL reset_direction got %b expected 0", direction); end
    n_checks++; if (index_seen !== 1'b0) begin n_fail++; $display("FAIL reset_index_seen got %b expected 0", index_seen); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b expected 0", error); end
    n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL reset_error_count got %0d expected 0", error_count); end
  endtask

  task automatic test_forward();
    do_reset();
    enable = 1'b1;
    enc_b  = 1'b1;
    repeat (5) tick();
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL fwd_latency_early got %0d expected 0", feedback); end
    tick();
    n_checks++; if (feedback !== 16'd1) begin n_fail++; $display("FAIL fwd_latency_exact got %0d expected 1", feedback); end
    repeat (4) tick();
    set_ab(1'b1, 1'b1, 10);
    set_ab(1'b1, 1'b0, 10);
    set_ab(1'b0, 1'b0, 10);
    for (int i = 0; i < 7; i++) up_cycle(10);
    n_checks++; if (feedback !== 16'd32) begin n_fail++; $display("FAIL fwd_feedback got %0d expected 32", feedback); end
    n_checks++; if (position !== 32'd32) begin n_fail++; $display("FAIL fwd_position got %0d expected 32", position); end
    n_checks++; if (direction !== 1'b1) begin n_fail++; $display("FAIL fwd_direction got %b expected 1", direction); end
  endtask

  task automatic test_reverse_wrap();
    do_reset();
    enable = 1'b1;
    set_ab(1'b1, 1'b0, 10);
    n_checks++; if (feedback !== 16'd1023) begin n_fail++; $display("FAIL rev_feedback got %0d expected 1023", feedback); end
    n_checks++; if (position !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rev_position got %0h expected ffffffff", position); end
    n_checks++; if (direction !== 1'b0) begin n_fail++; $display("FAIL rev_direction got %b expected 0", direction); end
    set_ab(1'b0, 1'b0, 10);
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL rev_upwrap_feedback got %0d expected 0", feedback); end
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL rev_upwrap_position got %0h expected 0", position); end
    n_checks++; if (direction !== 1'b1) begin n_fail++; $display("FAIL rev_upwrap_direction got %b expected 1", direction); end
  endtask

  task automatic test_glitch();
    do_reset();
    enable = 1'b1;
    set_ab(1'b1, 1'b0, 2);
    set_ab(1'b0, 1'b0, 12);
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL glitch_feedback got %0d expected 0", feedback); end
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL glitch_position got %0h expected 0", position); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL glitch_error got %b expected 0", error); end
  endtask

  task automatic test_index();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 75; i++) up_cycle(5);
    repeat (10) tick();
    n_checks++; if (feedback !== 16'd300) begin n_fail++; $display("FAIL idx_pre_feedback got %0d expected 300", feedback); end
    index_enable = 1'b1;
    enc_index = 1'b1;
    repeat (10) tick();
    enc_index = 1'b0;
    repeat (10) tick();
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL idx_feedback got %0d expected 0", feedback); end
    n_checks++; if (position !== 32'd300) begin n_fail++; $display("FAIL idx_position got %0d expected 300", position); end
    n_checks++; if (index_seen !== 1'b1) begin n_fail++; $display("FAIL idx_seen got %b expected 1", index_seen); end
    index_enable = 1'b0;
    up_cycle(10);
    enc_index = 1'b1;
    repeat (10) tick();
    enc_index = 1'b0;
    repeat (10) tick();
    n_checks++; if (feedback !== 16'd4) begin n_fail++; $display("FAIL idx_disabled_feedback got %0d expected 4", feedback); end
    n_checks++; if (position !== 32'd304) begin n_fail++; $display("FAIL idx_disabled_position got %0d expected 304", position); end
    do_reset();
    enable = 1'b1;
    enc_index = 1'b1;
    repeat (10) tick();
    enc_index = 1'b0;
    repeat (10) tick();
    n_checks++; if (index_seen !== 1'b0) begin n_fail++; $display("FAIL idx_unarmed_seen got %b expected 0", index_seen); end
  endtask

  task automatic test_illegal();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_ab(1'b1, 1'b1, 8);
      set_ab(1'b0, 1'b0, 8);
    end
    n_checks++; if (error_count !== 8'd10) begin n_fail++; $display("FAIL ill_count10 got %0d expected 10", error_count); end
    for (int i = 0; i < 145; i++) begin
      set_ab(1'b1, 1'b1, 8);
      set_ab(1'b0, 1'b0, 8);
    end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ill_error got %b expected 1", error); end
    n_checks++; if (error_count !== 8'd255) begin n_fail++; $display("FAIL ill_count_sat got %0d expected 255", error_count); end
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL ill_position got %0h expected 0", position); end
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL ill_feedback got %0d expected 0", feedback); end
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL clr_error got %b expected 0", error); end
    n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL clr_count got %0d expected 0", error_count); end
    for (int i = 0; i < 2; i++) begin
      set_ab(1'b1, 1'b1, 8);
      set_ab(1'b0, 1'b0, 8);
    end
    n_checks++; if (error_count !== 8'd4) begin n_fail++; $display("FAIL ill_count4 got %0d expected 4", error_count); end
    set_ab(1'b1, 1'b1, 5);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL clr_same_cycle_error got %b expected 1", error); end
    n_checks++; if (error_count !== 8'd1) begin n_fail++; $display("FAIL clr_same_cycle_count got %0d expected 1", error_count); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    enable = 1'b0;
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b1, 1'b1, 10);
    set_ab(1'b1, 1'b0, 10);
    set_ab(1'b0, 1'b0, 10);
    set_ab(1'b0, 1'b1, 10);
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL en_hold_feedback got %0d expected 0", feedback); end
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL en_hold_position got %0h expected 0", position); end
    enable = 1'b1;
    repeat (10) tick();
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL en_no_false_step got %0d expected 0", feedback); end
    set_ab(1'b1, 1'b1, 10);
    n_checks++; if (feedback !== 16'd1) begin n_fail++; $display("FAIL en_resume_feedback got %0d expected 1", feedback); end
    n_checks++; if (position !== 32'd1) begin n_fail++; $display("FAIL en_resume_position got %0d expected 1", position); end
    set_ab(1'b1, 1'b0, 3);
    rst = 1'b1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    tick();
    n_checks++; if (feedback !== 16'd0) begin n_fail++; $display("FAIL rst_mid_feedback got %0d expected 0", feedback); end
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL rst_mid_position got %0h expected 0", position); end
    n_checks++; if (direction !== 1'b0) begin n_fail++; $display("FAIL rst_mid_direction got %b expected 0", direction); end
    rst = 1'b0;
    repeat (12) tick();
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL rst_no_stale_step got %0h expected 0", position); end
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b1, 1'b1, 10);
    n_checks++; if (feedback !== 16'd2) begin n_fail++; $display("FAIL rst_resume_feedback got %0d expected 2", feedback); end
    n_checks++; if (position !== 32'd2) begin n_fail++; $display("FAIL rst_resume_position got %0d expected 2", position); end
    n_checks++; if (direction !== 1'b1) begin n_fail++; $display("FAIL rst_resume_direction got %b expected 1", direction); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_glitch();
    test_index();
    test_illegal();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bldc_encoder_angle.md
Name: bldc_encoder_angle

Overview:
- Quadrature encoder front end directly upstream of the BLDC sine-commutation stage.
- Converts raw A/B/index encoder pins into the 16-bit electrical rotor angle that drives that stage's `feedback` input, wrapped modulo one electrical revolution.
- Also provides a 32-bit signed mechanical position count and sticky fault/status flags for the host register interface.

Parameters:
- COUNTS_PER_EREV, 1024: encoder counts (x4 decoded) per electrical revolution. Must be 2..65535. With 1024 and a feedback divider of 16, the angle spans the 64-entry commutation table.
- FILTER_LEN, 3: consecutive identical synchronised samples required before a filtered input changes. 1..15.
- INDEX_POLARITY, 1: active level of the index pin.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  count enable; when low, counters hold
- enc_a  in  1  raw encoder channel A (asynchronous)
- enc_b  in  1  raw encoder channel B (asynchronous)
- enc_index  in  1  raw index pulse (asynchronous)
- index_enable  in  1  arm index re-zeroing of the angle
- clear_error  in  1  one-cycle pulse; clears error_count and error
- feedback  out  16  electrical angle, 0..COUNTS_PER_EREV-1
- position  out  32  signed accumulated position count
- direction  out  1  direction of the last valid step (1 = up)
- index_seen  out  1  sticky; set on the first accepted index
- error  out  1  sticky illegal-transition flag
- error_count  out  8  saturating illegal-transition counter

Behaviour:
- Reset: feedback=0, position=0, direction=0, index_seen=0, error=0, error_count=0. Synchroniser and filter state are cleared to 0, and the filtered previous state is 00.
- Reset mid-operation takes priority over every other event in the same cycle.
- Synchronisation: each raw input passes through a 2-FF synchroniser.
- Filtering:
  - A per-input counter increments while the synchronised value differs from the filtered value.
  - The counter resets to 0 when the values match.
  - When the counter reaches FILTER_LEN-1 and the values still differ, the filtered value updates on that edge.
- Decode:
  - The registered {A,B} filtered state is compared with the previous filtered state each cycle.
  - Gray sequence 00→01→11→10→00 = up step; the reverse = down step; no change = idle.
  - Both bits changing is illegal: no step, error←1, error_count+1 saturating at 255.
- Latency: an input change sampled at clock edge N is reflected on feedback/position after edge N+2+FILTER_LEN. That is FILTER_LEN+3 cycles total; 6 at the defaults.
- Step handling (only when enable=1):
  - Up step: position+1; feedback+1, wrapping COUNTS_PER_EREV-1→0.
  - Down step: position-1; feedback-1, wrapping 0→COUNTS_PER_EREV-1.
  - direction updates on every valid step.
  - position wraps as two's complement (0x7FFFFFFF+1 → 0x80000000).
- enable=0: the decode state still tracks the inputs (so re-enabling produces no false step), but feedback and position hold. Illegal transitions are still counted.
- Index:
  - Trigger is a filtered rising transition into INDEX_POLARITY while index_enable=1 and enable=1.
  - Effect: feedback←0 and index_seen←1. position is unaffected and still takes the step.
  - If index and a step occur in the same cycle, feedback is 0 (index wins).
  - An index with index_enable=0 is ignored and does not set index_seen.
- clear_error: clears error and error_count on the next edge. If an illegal transition occurs in the same cycle, the result is error=1 and error_count=1.
- Width rules: all feedback arithmetic is done in 17 bits before the modulo compare. Only a single ±1 step per cycle is possible, so wrap is a compare-and-select, never a divide.

Decomposition:
- Shared package bldc_pkg holds:
  - the quadrature state encodings,
  - the step codes (IDLE/UP/DOWN/ILLEGAL),
  - the decode function mapping {prev,cur} to a step code,
  - ERR_CNT_MAX=255.
- Sub-module quad_input_filter contains the 2-FF synchroniser and the FILTER_LEN stability counter, parameterised by FILTER_LEN. It is instanced three times (A, B, index).
- The top level contains decode, the angle/position counters, index logic and error logic.

Test Plan:
- Forward rotation: reset, enable=1, drive 8 full Gray cycles up (32 steps), each state held 10 cycles → feedback=32, position=32, direction=1. The first step is visible exactly 6 cycles after the input change.
- Reverse wrap: from reset, one down step → feedback=1023, position=-1 (0xFFFFFFFF), direction=0.
- Glitch rejection: pulse A high for 2 cycles (less than FILTER_LEN), then return → no step, feedback=0, error=0.
- Index re-zero: count up to 300, index_enable=1, raise index for 10 cycles → feedback=0, position=300, index_seen=1. Repeat with index_enable=0 → feedback unchanged.
- Illegal transition: switch 00→11 in one cycle, 300 times → error=1, error_count=255 (saturated), no position change. A clear_error pulse → error=0, error_count=0.
- Enable gating plus reset mid-run: with enable=0, step 5 up → feedback and position hold. Then assert rst during active stepping → all outputs 0 on the next edge, and counting resumes cleanly after rst drops.
